gray_ptr_ctrl: RTL and testbench



---
 rtl/gray_ptr_ctrl.sv | 112 +++++++++++
 tb/tb_gray_ptr_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_ctrl.sv
// gray_ptr_ctrl: one-side pointer and flag controller for an asynchronous FIFO.
// SIDE=0 lives in the write domain and produces "full".
// SIDE=1 lives in the read domain and produces "empty".
// The local pointer is kept in binary and Gray. The remote Gray pointer is
// brought in through a SYNC_STAGES flop chain and converted back to binary
// for the level computation.
//
// Handshake: inc is a request and the inverse of flag is its ready.
// A request is accepted on a rising edge where inc=1 and flag=0.
// A request made while flag=1 is dropped; err pulses for one cycle and the
// pointer holds.
module gray_ptr_ctrl #(
    parameter int ADDRSIZE    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SIDE        = 0,
    parameter int ALMOST_TH   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic [ADDRSIZE:0]   remote_gray_in,
    output logic [ADDRSIZE:0]   ptr_gray,
    output logic [ADDRSIZE-1:0] addr,
    output logic                flag,
    output logic                almost_flag,
    output logic [ADDRSIZE:0]   level,
    output logic                err
);

    localparam int PW = ADDRSIZE + 1;
    localparam logic [PW-1:0] DEPTH      = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic [PW-1:0] ALMOST_LVL = PW'(ALMOST_TH);
    localparam logic [PW-1:0] FULL_TH    = DEPTH - ALMOST_LVL;

    logic [PW-1:0] bin;
    logic [PW-1:0] bin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] rsync;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic          acc;
    logic          flag_next;
    logic          almost_next;

    assign rsync = sync_q[SYNC_STAGES-1];
    assign addr  = bin[ADDRSIZE-1:0];

    // Synchronizer chain for the remote Gray pointer (only one bit changes per step).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= remote_gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin = '0;
        for (int i = 0; i < PW; i++) begin
            rbin[i] = ^(rsync >> i);
        end
    end

    // Next pointer and next flags. Flags use the next pointer, so a local
    // increment sets the flag in the same edge and can never overrun.
    always_comb begin
        acc         = inc & ~flag;
        bin_next    = bin + {{ADDRSIZE{1'b0}}, acc};
        gray_next   = bin_next ^ (bin_next >> 1);
        flag_next   = 1'b0;
        level_next  = '0;
        almost_next = 1'b0;
        if (SIDE == 0) begin
            // Full: the pointers are one lap apart. In Gray code that means the
            // top two bits are inverted and the rest are equal.
            flag_next   = (gray_next == {~rsync[ADDRSIZE:ADDRSIZE-1], rsync[ADDRSIZE-2:0]});
            level_next  = bin_next - rbin;
            almost_next = (level_next >= FULL_TH);
        end else begin
            flag_next   = (gray_next == rsync);
            level_next  = rbin - bin_next;
            almost_next = (level_next <= ALMOST_LVL);
        end
    end

    // Pointer, flag and status registers. The read side resets to empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin         <= '0;
            ptr_gray    <= '0;
            flag        <= (SIDE != 0);
            almost_flag <= (SIDE != 0);
            level       <= '0;
            err         <= 1'b0;
        end else begin
            bin         <= bin_next;
            ptr_gray    <= gray_next;
            flag        <= flag_next;
            almost_flag <= almost_next;
            level       <= level_next;
            err         <= inc & flag;
        end
    end

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// tb_gray_ptr_ctrl: drives a write-side and a read-side instance.
// The reference model works on occupancy arithmetic over integer pointer counts.
// The remote pointer is delayed by a history queue of sampled values.
module tb_gray_ptr_ctrl;

  localparam int AW = 4;
  localparam int S  = 2;
  localparam int TH = 2;
  localparam int M  = 32;   // pointer modulus 2^(AW+1)
  localparam int D  = 16;   // FIFO depth

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic clk_run = 1'b0;
  logic rst_n   = 1'b1;

  initial begin
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  // ---------------- DUT signals ----------------
  logic       inc_w = 1'b0;
  logic       inc_r = 1'b0;
  logic [4:0] rem_w = '0;
  logic [4:0] rem_r = '0;
  logic [4:0] w_gray, r_gray, w_level, r_level;
  logic [3:0] w_addr, r_addr;
  logic       w_flag, r_flag, w_alm, r_alm, w_err, r_err;

  gray_ptr_ctrl #(.ADDRSIZE(AW), .SYNC_STAGES(S), .SIDE(0), .ALMOST_TH(TH)) u_wr (
    .clk(clk), .rst_n(rst_n), .inc(inc_w), .remote_gray_in(rem_w),
    .ptr_gray(w_gray), .addr(w_addr), .flag(w_flag), .almost_flag(w_alm),
    .level(w_level), .err(w_err)
  );

  gray_ptr_ctrl #(.ADDRSIZE(AW), .SYNC_STAGES(S), .SIDE(1), .ALMOST_TH(TH)) u_rd (
    .clk(clk), .rst_n(rst_n), .inc(inc_r), .remote_gray_in(rem_r),
    .ptr_gray(r_gray), .addr(r_addr), .flag(r_flag), .almost_flag(r_alm),
    .level(r_level), .err(r_err)
  );

  // ---------------- reference model ----------------
  int checks   = 0;
  int failures = 0;
  logic [33:0] exp_q[$];

  int m_wb, m_rb;
  bit m_wf, m_rf;
  int hist_w[$];
  int hist_r[$];

  localparam logic [33:0] RESET_EXP = {17'b0, 5'b0, 4'b0, 1'b1, 1'b1, 5'b0, 1'b0};

  function automatic logic [4:0] to_gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [16:0] pack(input int b, input bit f, input bit a,
                                       input int lvl, input bit e);
    logic [4:0] bv;
    bv = 5'(b);
    return {to_gray(b), bv[3:0], f, a, 5'(lvl), e};
  endfunction

  task automatic model_reset();
    m_wb = 0;
    m_rb = 0;
    m_wf = 1'b0;
    m_rf = 1'b1;
    hist_w.delete();
    hist_r.delete();
    for (int i = 0; i < S; i++) begin
      hist_w.push_back(0);
      hist_r.push_back(0);
    end
  endtask

  // One rising edge of both sides; rw/rr are remote pointer counts in binary.
  task automatic model_edge(input bit iw, input int rw, input bit ir, input int rr,
                            output logic [33:0] e);
    int r, bn, lvl;
    bit acc, er, f, a;
    logic [16:0] ew, erd;
    // write side: occupancy = written - read
    r = hist_w.pop_front();
    hist_w.push_back(rw);
    acc = iw && !m_wf;
    er  = iw && m_wf;
    bn  = (m_wb + (acc ? 1 : 0)) % M;
    lvl = (bn - r + M) % M;
    f   = (lvl == D);
    a   = (lvl >= D - TH);
    ew  = pack(bn, f, a, lvl, er);
    m_wb = bn;
    m_wf = f;
    // read side: occupancy = written - read
    r = hist_r.pop_front();
    hist_r.push_back(rr);
    acc = ir && !m_rf;
    er  = ir && m_rf;
    bn  = (m_rb + (acc ? 1 : 0)) % M;
    lvl = (r - bn + M) % M;
    f   = (lvl == 0);
    a   = (lvl <= TH);
    erd = pack(bn, f, a, lvl, er);
    m_rb = bn;
    m_rf = f;
    e = {ew, erd};
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit iw, input int rw, input bit ir, input int rr);
    logic [33:0] e;
    @(negedge clk);
    inc_w = iw;
    rem_w = to_gray(rw);
    inc_r = ir;
    rem_r = to_gray(rr);
    model_edge(iw, rw, ir, rr, e);
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Asynchronous reset between edges, with the inputs left as they were.
  task automatic do_reset();
    @(posedge clk);
    #2;
    exp_q.push_back(RESET_EXP);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    inc_w = 1'b0;
    inc_r = 1'b0;
    rem_w = '0;
    rem_r = '0;
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk or negedge rst_n) begin
    logic [33:0] e;
    logic [33:0] act;
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {w_gray, w_addr, w_flag, w_alm, w_level, w_err,
             r_gray, r_addr, r_flag, r_alm, r_level, r_err};
      checks = checks + 1;
      if (act[33:17] !== e[33:17]) begin
        failures = failures + 1;
        $display("FAIL wr_side t=%0t got gray=%b addr=%0d flag=%b alm=%b lvl=%0d err=%b want gray=%b addr=%0d flag=%b alm=%b lvl=%0d err=%b",
                 $time, act[33:29], act[28:25], act[24], act[23], act[22:18], act[17],
                 e[33:29], e[28:25], e[24], e[23], e[22:18], e[17]);
      end
      checks = checks + 1;
      if (act[16:0] !== e[16:0]) begin
        failures = failures + 1;
        $display("FAIL rd_side t=%0t got gray=%b addr=%0d flag=%b alm=%b lvl=%0d err=%b want gray=%b addr=%0d flag=%b alm=%b lvl=%0d err=%b",
                 $time, act[16:12], act[11:8], act[7], act[6], act[5:1], act[0],
                 e[16:12], e[11:8], e[7], e[6], e[5:1], e[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  int rpw;   // read pointer seen by the write side
  int wpr;   // write pointer seen by the read side

  initial begin
    bit iw, ir;
    model_reset();
    // Reset with the clock stopped.
    exp_q.push_back(RESET_EXP);
    #7 rst_n = 1'b0;
    #5 rst_n = 1'b1;
    #3 clk_run = 1'b1;

    rpw = 0;
    wpr = 0;
    // Fill the write side until full, then one rejected write.
    repeat (17) step(1'b1, rpw, 1'b0, wpr);
    step(1'b0, rpw, 1'b0, wpr);
    // Full, then the remote read pointer moves while the writer keeps requesting.
    rpw = 1;
    repeat (5) step(1'b1, rpw, 1'b0, wpr);
    // Read side: the remote write pointer jumps to 3, then pops until an underflow.
    wpr = 3;
    repeat (3) step(1'b0, rpw, 1'b0, wpr);
    repeat (4) step(1'b0, rpw, 1'b1, wpr);

    // Reset during a write burst at level 9.
    do_reset();
    rpw = 0;
    wpr = 0;
    repeat (9) step(1'b1, rpw, 1'b0, wpr);
    do_reset();
    step(1'b1, 0, 1'b0, 0);

    // Wrap: the remote read pointer stays just behind the writer.
    for (int i = 0; i < 40; i++) begin
      rpw = (m_wb - 1 + M) % M;
      step(1'b1, rpw, 1'b0, wpr);
    end

    // Random traffic. Both remote pointers move legally relative to the local counts.
    for (int i = 0; i < 400; i++) begin
      iw = ($urandom_range(0, 3) != 0);
      ir = ($urandom_range(0, 1) == 1);
      if (((m_wb - rpw + M) % M) > 0 && $urandom_range(0, 2) == 0)
        rpw = (rpw + 1) % M;
      if (((wpr - m_rb + M) % M) < D && $urandom_range(0, 2) == 0)
        wpr = (wpr + 1) % M;
      step(iw, rpw, ir, wpr);
    end

    repeat (3) @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
